// File: rtl/mem_responder_if.sv
// Request/response bus between the accumulator controller and its memory responder.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_ready;
  logic              busy;
  logic              err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, mem_ready, busy, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, mem_ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: latches one request in IDLE, waits WAIT_STATES
// cycles, then completes it with a one-cycle mem_ready pulse.
module mem_responder #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   mem_if
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              conflict_q, conflict_d;
  logic              err_d;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q, busy_q, err_q;
  logic              enter_resp_c;
  logic [DATA_W-1:0] resp_data_c;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Next-state logic; conflict_q keeps err to a single pulse while both requests stay high
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    conflict_d = conflict_q;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        conflict_d = 1'b0;
        if (mem_if.mem_read ^ mem_if.mem_write) begin
          wr_d    = mem_if.mem_write;
          addr_d  = mem_if.addr;
          wdata_d = mem_if.wdata;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = S_RESP;
          end
        end else if (mem_if.mem_read && mem_if.mem_write) begin
          conflict_d = 1'b1;
          err_d      = !conflict_q;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RESP is only ever entered from IDLE or WAIT, so this marks the committing edge
  assign enter_resp_c = (state_d == S_RESP);
  assign resp_data_c  = wr_d ? wdata_d : mem_q[addr_d];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      conflict_q <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      conflict_q <= conflict_d;
      ready_q    <= enter_resp_c;
      busy_q     <= (state_d != S_IDLE);
      err_q      <= err_d;
      if (enter_resp_c) rdata_q <= resp_data_c;
    end
  end

  // Storage survives reset; a write lands on the edge entering RESP
  always_ff @(posedge clk) begin
    if (enter_resp_c && wr_d) mem_q[addr_d] <= wdata_d;
  end

  assign mem_if.rdata     = rdata_q;
  assign mem_if.mem_ready = ready_q;
  assign mem_if.busy      = busy_q;
  assign mem_if.err       = err_q;

endmodule
